// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the pipelined controller: opcode/func codes, ALU op encoding and
// control-bundle bit layout. `CTRL_MULDIV_EN enables mul/div and HI/LO decode.
package ctrl_pipe_pkg;

`ifdef CTRL_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  localparam int ALU_W = 4;

  typedef enum logic [ALU_W-1:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_ADDU = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_SUBU = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_SLT  = 4'd11,
    ALU_SLTU = 4'd12
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Control-bundle bit positions (LSB first).
  localparam int CB_MEMTOREG = 0;
  localparam int CB_REGWRITE = 1;
  localparam int CB_WRITEMEM = 2;
  localparam int CB_READMEM  = 3;
  localparam int CB_PC_JUMP  = 4;
  localparam int CB_SHIFT    = 5;
  localparam int CB_REGDST   = 7;
  localparam int CB_ALUSRC   = 8;
  localparam int CB_ALUOP    = 9;
  localparam int CB_W        = CB_ALUOP + ALU_W;

  typedef logic [CB_W-1:0] ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/func decode into the packed control bundle plus mul/div and HI/LO flags.
// Mul/div funcs decode only when `CTRL_MULDIV_EN is defined (via MULDIV_EN).
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output ctrl_t      ctrl,
  output logic       is_muldiv,
  output logic       is_hilo
);

  alu_op_e    aluop;
  logic       alusrc;
  logic       regdst;
  logic [1:0] shift;
  logic       pc_jump;
  logic       readmem;
  logic       writemem;
  logic       regwrite;
  logic       memtoreg;

  always_comb begin
    aluop     = ALU_NOP;
    alusrc    = 1'b0;
    regdst    = 1'b0;
    shift     = 2'd0;
    pc_jump   = 1'b0;
    readmem   = 1'b0;
    writemem  = 1'b0;
    regwrite  = 1'b0;
    memtoreg  = 1'b0;
    is_muldiv = 1'b0;
    is_hilo   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        case (func)
          FN_ADD:  aluop = ALU_ADD;
          FN_ADDU: aluop = ALU_ADDU;
          FN_SUB:  aluop = ALU_SUB;
          FN_SUBU: aluop = ALU_SUBU;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_NOR:  aluop = ALU_NOR;
          FN_SLT:  aluop = ALU_SLT;
          FN_SLL:  begin aluop = ALU_SLL; shift = 2'd1; end
          FN_SRL:  begin aluop = ALU_SRL; shift = 2'd1; end
          FN_SRA:  begin aluop = ALU_SRA; shift = 2'd1; end
          FN_JR:   begin pc_jump = 1'b1; regwrite = 1'b0; end
          FN_MFHI, FN_MFLO: begin
            is_hilo  = MULDIV_EN;
            regdst   = MULDIV_EN;
            regwrite = MULDIV_EN;
          end
          // Mul/div results land in HI/LO, so no GPR write-back is issued here.
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            is_muldiv = MULDIV_EN;
            regdst    = 1'b0;
            regwrite  = 1'b0;
          end
          default: begin
            regdst   = 1'b0;
            regwrite = 1'b0;
          end
        endcase
      end
      OP_ADDI:  begin aluop = ALU_ADD;  alusrc = 1'b1; regwrite = 1'b1; end
      OP_ADDIU: begin aluop = ALU_ADDU; alusrc = 1'b1; regwrite = 1'b1; end
      OP_SLTI:  begin aluop = ALU_SLT;  alusrc = 1'b1; regwrite = 1'b1; end
      OP_SLTIU: begin aluop = ALU_SLTU; alusrc = 1'b1; regwrite = 1'b1; end
      OP_ANDI:  begin aluop = ALU_AND;  alusrc = 1'b1; regwrite = 1'b1; end
      OP_ORI:   begin aluop = ALU_OR;   alusrc = 1'b1; regwrite = 1'b1; end
      OP_LW, OP_LBU, OP_LHU: begin
        aluop    = ALU_ADD;
        alusrc   = 1'b1;
        readmem  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      OP_LUI: begin
        aluop    = ALU_SLL;
        alusrc   = 1'b1;
        shift    = 2'd2;
        regwrite = 1'b1;
      end
      OP_SB, OP_SH: begin
        aluop    = ALU_ADD;
        alusrc   = 1'b1;
        writemem = 1'b1;
      end
      OP_BEQ, OP_BNE: aluop = ALU_SUB;
      default: ;
    endcase
  end

  assign ctrl = {aluop, alusrc, regdst, shift, pc_jump, readmem, writemem, regwrite, memtoreg};

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined main controller: ID decode carried through ID/EX, EX/MEM, MEM/WB with stall/flush.
// `CTRL_MULDIV_EN adds the mul/div busy tracker and its self-generated stall.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int MD_CYCLES = 8,
  parameter int ALUOP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               id_valid,
  input  logic               stall_in,
  input  logic               flush,
  output logic               stall_out,
  output logic               md_busy,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_alusrc,
  output logic               ex_regdst,
  output logic [1:0]         ex_shift,
  output logic               ex_pc_jump,
  output logic               mem_valid,
  output logic               mem_readmem,
  output logic               mem_writemem,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic               wb_memtoreg
);

  if (MD_CYCLES < 2 || MD_CYCLES > 64) begin : g_md_cycles_range
    $error("ctrl_pipe: MD_CYCLES must be in 2..64");
  end

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  is_muldiv;
  logic  is_hilo;
  logic  bubble;
  logic  mem_rd_q, mem_wr_q, mem_rw_q, mem_m2r_q;
  logic  wb_rw_q, wb_m2r_q;

  ctrl_decode u_decode (
    .opcode    (opcode),
    .func      (func),
    .ctrl      (id_ctrl),
    .is_muldiv (is_muldiv),
    .is_hilo   (is_hilo)
  );

  assign bubble = !id_valid | flush | stall_in | stall_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      mem_valid <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
      mem_m2r_q <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rw_q   <= 1'b0;
      wb_m2r_q  <= 1'b0;
    end else begin
      ex_valid  <= !bubble;
      ex_ctrl   <= bubble ? '0 : id_ctrl;
      // Downstream stages free-run; only the fields consumed later are carried on.
      mem_valid <= ex_valid;
      mem_rd_q  <= ex_ctrl[CB_READMEM];
      mem_wr_q  <= ex_ctrl[CB_WRITEMEM];
      mem_rw_q  <= ex_ctrl[CB_REGWRITE];
      mem_m2r_q <= ex_ctrl[CB_MEMTOREG];
      wb_valid  <= mem_valid;
      wb_rw_q   <= mem_rw_q;
      wb_m2r_q  <= mem_m2r_q;
    end
  end

  assign ex_aluop     = ex_valid ? ALUOP_W'(ex_ctrl[CB_ALUOP +: ALU_W]) : '0;
  assign ex_alusrc    = ex_valid & ex_ctrl[CB_ALUSRC];
  assign ex_regdst    = ex_valid & ex_ctrl[CB_REGDST];
  assign ex_shift     = ex_valid ? ex_ctrl[CB_SHIFT +: 2] : 2'd0;
  assign ex_pc_jump   = ex_valid & ex_ctrl[CB_PC_JUMP];
  assign mem_readmem  = mem_valid & mem_rd_q;
  assign mem_writemem = mem_valid & mem_wr_q;
  assign wb_regwrite  = wb_valid & wb_rw_q;
  assign wb_memtoreg  = wb_valid & wb_m2r_q;

`ifdef CTRL_MULDIV_EN
  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  logic [CNT_W-1:0] md_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (!bubble && is_muldiv) begin
      md_cnt <= CNT_W'(MD_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_busy   = (md_cnt != '0);
  assign stall_out = md_busy & id_valid & (is_muldiv | is_hilo);
`else
  logic unused_md_flags;
  assign unused_md_flags = is_muldiv | is_hilo;
  assign md_busy         = 1'b0;
  assign stall_out       = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  localparam int MD = 8;
  localparam int AW = 4;
`ifdef CTRL_MULDIV_EN
  localparam bit MDEN = 1'b1;
`else
  localparam bit MDEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    func = '0;
  logic          id_valid = 1'b0;
  logic          stall_in = 1'b0;
  logic          flush = 1'b0;
  logic          stall_out, md_busy;
  logic          ex_valid, ex_alusrc, ex_regdst, ex_pc_jump;
  logic [AW-1:0] ex_aluop;
  logic [1:0]    ex_shift;
  logic          mem_valid, mem_readmem, mem_writemem;
  logic          wb_valid, wb_regwrite, wb_memtoreg;

  int checks = 0;
  int errs   = 0;

  ctrl_pipe #(.MD_CYCLES(MD), .ALUOP_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .id_valid(id_valid),
    .stall_in(stall_in), .flush(flush), .stall_out(stall_out), .md_busy(md_busy),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
    .ex_shift(ex_shift), .ex_pc_jump(ex_pc_jump), .mem_valid(mem_valid),
    .mem_readmem(mem_readmem), .mem_writemem(mem_writemem), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       v;
    logic [3:0] aluop;
    logic       alusrc, regdst;
    logic [1:0] shift;
    logic       pc_jump, rd, wr, rw, m2r, md, hilo;
  } exp_t;

  function automatic exp_t model_decode(input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    e = '0;
    e.v = 1'b1;
    if (op == 6'h00) begin
      e.regdst = 1'b1;
      e.rw     = 1'b1;
      case (fn)
        6'h20: e.aluop = ALU_ADD;
        6'h21: e.aluop = ALU_ADDU;
        6'h22: e.aluop = ALU_SUB;
        6'h23: e.aluop = ALU_SUBU;
        6'h24: e.aluop = ALU_AND;
        6'h25: e.aluop = ALU_OR;
        6'h27: e.aluop = ALU_NOR;
        6'h2A: e.aluop = ALU_SLT;
        6'h00: begin e.aluop = ALU_SLL; e.shift = 2'd1; end
        6'h02: begin e.aluop = ALU_SRL; e.shift = 2'd1; end
        6'h03: begin e.aluop = ALU_SRA; e.shift = 2'd1; end
        6'h08: begin e.pc_jump = 1'b1; e.rw = 1'b0; end
        6'h10, 6'h12: begin e.hilo = MDEN; e.regdst = MDEN; e.rw = MDEN; end
        6'h18, 6'h19, 6'h1A, 6'h1B: begin e.md = MDEN; e.regdst = 1'b0; e.rw = 1'b0; end
        default: begin e.regdst = 1'b0; e.rw = 1'b0; end
      endcase
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D}) begin
      e.alusrc = 1'b1;
      e.rw     = 1'b1;
      case (op)
        6'h08:   e.aluop = ALU_ADD;
        6'h09:   e.aluop = ALU_ADDU;
        6'h0A:   e.aluop = ALU_SLT;
        6'h0B:   e.aluop = ALU_SLTU;
        6'h0C:   e.aluop = ALU_AND;
        default: e.aluop = ALU_OR;
      endcase
    end else if (op inside {6'h23, 6'h24, 6'h25}) begin
      e.aluop = ALU_ADD; e.alusrc = 1'b1; e.rd = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
    end else if (op == 6'h0F) begin
      e.aluop = ALU_SLL; e.alusrc = 1'b1; e.shift = 2'd2; e.rw = 1'b1;
    end else if (op inside {6'h28, 6'h29}) begin
      e.aluop = ALU_ADD; e.alusrc = 1'b1; e.wr = 1'b1;
    end else if (op inside {6'h04, 6'h05}) begin
      e.aluop = ALU_SUB;
    end
    return e;
  endfunction

  exp_t pipe_ex = '0, pipe_mem = '0, pipe_wb = '0;
  int   cyc = 0;
  int   md_free = 0;   // first cycle index at which the mul/div unit is idle again
  exp_t id_dec;
  logic exp_busy, exp_stall, exp_bubble;

  assign id_dec     = model_decode(opcode, func);
  assign exp_busy   = (cyc < md_free);
  assign exp_stall  = id_valid && exp_busy && (id_dec.md || id_dec.hilo);
  assign exp_bubble = !id_valid || flush || stall_in || exp_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_ex  <= '0;
      pipe_mem <= '0;
      pipe_wb  <= '0;
      md_free  <= 0;
    end else begin
      cyc      <= cyc + 1;
      pipe_wb  <= pipe_mem;
      pipe_mem <= pipe_ex;
      pipe_ex  <= exp_bubble ? '0 : id_dec;
      if (!exp_bubble && id_dec.md) md_free <= cyc + MD + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_stall_out",    stall_out,    exp_stall);
      chk("cmp_md_busy",      md_busy,      exp_busy);
      chk("cmp_ex_valid",     ex_valid,     pipe_ex.v);
      chk("cmp_ex_aluop",     ex_aluop,     pipe_ex.aluop);
      chk("cmp_ex_alusrc",    ex_alusrc,    pipe_ex.alusrc);
      chk("cmp_ex_regdst",    ex_regdst,    pipe_ex.regdst);
      chk("cmp_ex_shift",     ex_shift,     pipe_ex.shift);
      chk("cmp_ex_pc_jump",   ex_pc_jump,   pipe_ex.pc_jump);
      chk("cmp_mem_valid",    mem_valid,    pipe_mem.v);
      chk("cmp_mem_readmem",  mem_readmem,  pipe_mem.rd);
      chk("cmp_mem_writemem", mem_writemem, pipe_mem.wr);
      chk("cmp_wb_valid",     wb_valid,     pipe_wb.v);
      chk("cmp_wb_regwrite",  wb_regwrite,  pipe_wb.rw);
      chk("cmp_wb_memtoreg",  wb_memtoreg,  pipe_wb.m2r);
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] op_tab [0:19] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h05,
                                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23,
                                6'h24, 6'h28, 6'h29, 6'h3F};
  logic [5:0] fn_tab [0:19] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h10, 6'h12, 6'h18, 6'h19,
                                6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h27, 6'h2A, 6'h18, 6'h2B};

  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic v, input logic st, input logic fl);
    opcode = op; func = fn; id_valid = v; stall_in = st; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    issue(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  int n;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ex_valid",  ex_valid,  0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_wb_valid",  wb_valid,  0);
    chk("rst_md_busy",   md_busy,   0);
    chk("rst_stall_out", stall_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADDI through all stages
    issue(6'h08, 6'h00, 1'b1, 1'b0, 1'b0);
    chk("addi_ex_alusrc", ex_alusrc, 1);
    chk("addi_ex_aluop", ex_aluop, 1);
    idle();
    chk("addi_mem_valid", mem_valid, 1);
    idle();
    chk("addi_wb_regwrite", wb_regwrite, 1);

    // LW then SB
    issue(6'h23, 6'h00, 1'b1, 1'b0, 1'b0);
    chk("lw_ex_alusrc", ex_alusrc, 1);
    issue(6'h28, 6'h00, 1'b1, 1'b0, 1'b0);
    chk("lw_mem_readmem", mem_readmem, 1);
    idle();
    chk("lw_wb_memtoreg", wb_memtoreg, 1);
    chk("sb_mem_writemem", mem_writemem, 1);
    idle();
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_wb_regwrite", wb_regwrite, 0);

    // ADD held by external stall while an older ADDI drains
    issue(6'h08, 6'h00, 1'b1, 1'b0, 1'b0);
    issue(6'h00, 6'h20, 1'b1, 1'b1, 1'b0);
    chk("stall1_ex_valid", ex_valid, 0);
    chk("stall1_mem_valid", mem_valid, 1);
    issue(6'h00, 6'h20, 1'b1, 1'b1, 1'b0);
    chk("stall2_ex_valid", ex_valid, 0);
    chk("stall2_wb_regwrite", wb_regwrite, 1);
    issue(6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
    chk("add_ex_valid", ex_valid, 1);
    chk("add_ex_aluop", ex_aluop, 1);
    chk("add_ex_regdst", ex_regdst, 1);

    // JR flushed, then JR unflushed; SLL shift, LUI shift
    issue(6'h00, 6'h08, 1'b1, 1'b0, 1'b1);
    chk("jrflush_ex_valid", ex_valid, 0);
    chk("jrflush_ex_pc_jump", ex_pc_jump, 0);
    issue(6'h00, 6'h08, 1'b1, 1'b1, 1'b1);
    chk("jrflushstall_ex_valid", ex_valid, 0);
    issue(6'h00, 6'h08, 1'b1, 1'b0, 1'b0);
    chk("jr_ex_pc_jump", ex_pc_jump, 1);
    issue(6'h00, 6'h03, 1'b1, 1'b0, 1'b0);
    chk("sra_ex_shift", ex_shift, 1);
    issue(6'h0F, 6'h00, 1'b1, 1'b0, 1'b0);
    chk("lui_ex_shift", ex_shift, 2);
    chk("lui_ex_aluop", ex_aluop, 8);
    issue(6'h3F, 6'h00, 1'b1, 1'b0, 1'b0);
    chk("unk_ex_valid", ex_valid, 1);
    chk("unk_ex_aluop", ex_aluop, 0);
    idle();

    // MULT: busy duration
    issue(6'h00, 6'h18, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!md_busy) break;
      n++;
      idle();
    end
    chk("mult_busy_cycles", n, MDEN ? MD : 0);

    // MULT, ADD issues freely, MFLO waits for the unit
    issue(6'h00, 6'h18, 1'b1, 1'b0, 1'b0);
    issue(6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
    chk("mult_add_ex_valid", ex_valid, 1);
    chk("mult_add_ex_aluop", ex_aluop, 1);
    opcode = 6'h00; func = 6'h12; id_valid = 1'b1; stall_in = 1'b0; flush = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!stall_out) break;
      n++;
      @(posedge clk); #1;
    end
    chk("mflo_stall_cycles", n, MDEN ? MD - 1 : 0);
    @(posedge clk); #1;
    chk("mflo_ex_valid", ex_valid, 1);
    chk("mflo_ex_regdst", ex_regdst, MDEN ? 1 : 0);
    chk("mflo_md_busy", md_busy, 0);
    idle();

    // Asynchronous reset while the unit is busy
    issue(6'h08, 6'h00, 1'b1, 1'b0, 1'b0);
    issue(6'h00, 6'h1A, 1'b1, 1'b0, 1'b0);
    chk("div_md_busy", md_busy, MDEN ? 1 : 0);
    opcode = 6'h00; func = 6'h10; id_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_md_busy", md_busy, 0);
    chk("arst_stall_out", stall_out, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_post_md_busy", md_busy, 0);
    chk("arst_post_ex_valid", ex_valid, 1);
    idle();

    // Randomized traffic, checked every cycle by the compare process
    for (int k = 0; k < 600; k++) begin
      logic [5:0] op, fn;
      op = op_tab[$urandom_range(0, 19)];
      fn = fn_tab[$urandom_range(0, 19)];
      if ($urandom_range(0, 15) == 0) fn = 6'($urandom);
      issue(op, fn, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 1),
            ($urandom_range(0, 9) < 1));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
